// File: rtl/bpred_resolve_unit.sv
// Branch resolution unit: queues fetch-side predictions, matches in-order outcomes from
// execute, and raises a mispredict redirect and predictor training updates.
module bpred_resolve_unit #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3,
  parameter int unsigned PC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic              pred_taken,
  input  logic [PC_W-1:0]   pred_pc,
  input  logic [PC_W-1:0]   pred_alt_pc,
  output logic              pred_ready,
  input  logic              res_valid,
  input  logic              res_taken,
  output logic              res_ready,
  input  logic              ext_flush,
  output logic              mispredict,
  output logic [PC_W-1:0]   recover_pc,
  output logic              upd_valid,
  output logic [PC_W-1:0]   upd_pc,
  output logic              upd_taken,
  output logic [PTR_W:0]    inflight_cnt,
  output logic [15:0]       mispred_cnt
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DEPTH-1:0]  taken_mem;
  logic [PC_W-1:0]   pc_mem  [DEPTH];
  logic [PC_W-1:0]   alt_mem [DEPTH];
  logic              push, pop, miss;

  assign inflight_cnt = count;

  // Handshake decode and next-state; RECOVER is a one-cycle redirect bubble.
  always_comb begin
    state_nxt  = state;
    pred_ready = 1'b0;
    res_ready  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    miss       = 1'b0;
    case (state)
      RUN: begin
        pred_ready = (count != FULL);
        res_ready  = (count != '0);
        push       = pred_valid & pred_ready;
        pop        = res_valid & res_ready;
        miss       = pop & (res_taken != taken_mem[rd_ptr]);
        if (miss) state_nxt = RECOVER;
      end
      RECOVER: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (ext_flush) state_nxt = RUN;
  end

  // Entry storage; stale contents are harmless because pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      taken_mem[wr_ptr] <= pred_taken;
      pc_mem[wr_ptr]    <= pred_pc;
      alt_mem[wr_ptr]   <= pred_alt_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mispredict  <= 1'b0;
      recover_pc  <= '0;
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_taken   <= 1'b0;
      mispred_cnt <= '0;
    end else begin
      state      <= state_nxt;
      mispredict <= 1'b0;
      upd_valid  <= 1'b0;
      if (ext_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop) begin
          upd_valid <= 1'b1;
          upd_pc    <= pc_mem[rd_ptr];
          upd_taken <= res_taken;
        end
        // Everything behind a mispredicted head is wrong-path, including a same-cycle push.
        if (miss) begin
          mispredict <= 1'b1;
          recover_pc <= alt_mem[rd_ptr];
          if (mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push) wr_ptr <= wr_ptr + PTR_W'(1);
          if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
          case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bpred_resolve_unit.sv
// Self-checking bench for bpred_resolve_unit: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_bpred_resolve_unit;

  logic        clk = 1'b0;
  logic        rst, pred_valid, pred_taken, res_valid, res_taken, ext_flush;
  logic [15:0] pred_pc, pred_alt_pc;
  logic        pred_ready, res_ready, mispredict, upd_valid, upd_taken;
  logic [15:0] recover_pc, upd_pc, mispred_cnt;
  logic [3:0]  inflight_cnt;

  int checks = 0;
  int passed = 0;

  typedef struct packed {logic tk; logic [15:0] pc; logic [15:0] alt;} ent_t;

  always #5 clk = ~clk;

  bpred_resolve_unit dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_alt_pc(pred_alt_pc), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .ext_flush(ext_flush), .mispredict(mispredict), .recover_pc(recover_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .inflight_cnt(inflight_cnt), .mispred_cnt(mispred_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic pt, input logic [15:0] pc,
                       input logic [15:0] alt, input logic rv, input logic rt,
                       input logic fl);
    pred_valid = pv; pred_taken = pt; pred_pc = pc; pred_alt_pc = alt;
    res_valid = rv; res_taken = rt; ext_flush = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0BAD, 16'h0BAE, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    checks++; if (mispredict !== 1'b0) $display("FAIL reset_mispredict got %0h exp 0", mispredict); else passed++;
    checks++; if (recover_pc !== 16'h0) $display("FAIL reset_recover_pc got %0h exp 0", recover_pc); else passed++;
    checks++; if (upd_valid !== 1'b0) $display("FAIL reset_upd_valid got %0h exp 0", upd_valid); else passed++;
    checks++; if (upd_pc !== 16'h0) $display("FAIL reset_upd_pc got %0h exp 0", upd_pc); else passed++;
    checks++; if (upd_taken !== 1'b0) $display("FAIL reset_upd_taken got %0h exp 0", upd_taken); else passed++;
    checks++; if (pred_ready !== 1'b1) $display("FAIL reset_pred_ready got %0h exp 1", pred_ready); else passed++;
    checks++; if (res_ready !== 1'b0) $display("FAIL reset_res_ready got %0h exp 0", res_ready); else passed++;
    checks++; if (inflight_cnt !== 4'd0) $display("FAIL reset_inflight got %0d exp 0", inflight_cnt); else passed++;
    checks++; if (mispred_cnt !== 16'h0) $display("FAIL reset_mispred_cnt got %0h exp 0", mispred_cnt); else passed++;
  endtask

  task automatic test_correct_path();
    drive(1'b1, 1'b1, 16'h0010, 16'h0011, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (res_ready !== 1'b1) $display("FAIL cp_res_ready got %0h exp 1", res_ready); else passed++;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
    tick();
    checks++; if (upd_valid !== 1'b1) $display("FAIL cp_upd_valid got %0h exp 1", upd_valid); else passed++;
    checks++; if (upd_pc !== 16'h0010) $display("FAIL cp_upd_pc got %0h exp 10", upd_pc); else passed++;
    checks++; if (upd_taken !== 1'b1) $display("FAIL cp_upd_taken got %0h exp 1", upd_taken); else passed++;
    checks++; if (mispredict !== 1'b0) $display("FAIL cp_mispredict got %0h exp 0", mispredict); else passed++;
    checks++; if (inflight_cnt !== 4'd0) $display("FAIL cp_inflight got %0d exp 0", inflight_cnt); else passed++;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (upd_valid !== 1'b0) $display("FAIL cp_upd_pulse got %0h exp 0", upd_valid); else passed++;
  endtask

  task automatic test_mispredict();
    drive(1'b1, 1'b0, 16'h0020, 16'h0025, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 16'h0030, 16'h0031, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 16'h0040, 16'h0041, 1'b0, 1'b0, 1'b0); tick();
    checks++; if (inflight_cnt !== 4'd3) $display("FAIL mp_fill got %0d exp 3", inflight_cnt); else passed++;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (mispredict !== 1'b1) $display("FAIL mp_pulse got %0h exp 1", mispredict); else passed++;
    checks++; if (recover_pc !== 16'h0025) $display("FAIL mp_recover_pc got %0h exp 25", recover_pc); else passed++;
    checks++; if (inflight_cnt !== 4'd0) $display("FAIL mp_inflight got %0d exp 0", inflight_cnt); else passed++;
    checks++; if (pred_ready !== 1'b0) $display("FAIL mp_bubble got %0h exp 0", pred_ready); else passed++;
    checks++; if (mispred_cnt !== 16'd1) $display("FAIL mp_cnt got %0d exp 1", mispred_cnt); else passed++;
    checks++; if (upd_pc !== 16'h0020) $display("FAIL mp_upd_pc got %0h exp 20", upd_pc); else passed++;
    tick();
    checks++; if (mispredict !== 1'b0) $display("FAIL mp_pulse_end got %0h exp 0", mispredict); else passed++;
    checks++; if (pred_ready !== 1'b1) $display("FAIL mp_ready_back got %0h exp 1", pred_ready); else passed++;
  endtask

  task automatic test_full_wrap();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 1'(i & 1), 16'(32'h100 + b * 32'h200 + i), 16'(32'h800 + i), 1'b0, 1'b0, 1'b0);
        tick();
      end
      checks++; if (inflight_cnt !== 4'd8) $display("FAIL fw_full_cnt got %0d exp 8", inflight_cnt); else passed++;
      checks++; if (pred_ready !== 1'b0) $display("FAIL fw_full_ready got %0h exp 0", pred_ready); else passed++;
      drive(1'b1, 1'b0, 16'h01FF, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (inflight_cnt !== 4'd8) $display("FAIL fw_overflow got %0d exp 8", inflight_cnt); else passed++;
      for (int i = 0; i < 8; i++) begin
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'(i & 1), 1'b0);
        tick();
        checks++;
        if (upd_valid !== 1'b1 || upd_pc !== 16'(32'h100 + b * 32'h200 + i) || mispredict !== 1'b0)
          $display("FAIL fw_order[%0d] got v=%0h pc=%0h mp=%0h exp v=1 pc=%0h mp=0", i, upd_valid,
                   upd_pc, mispredict, 16'(32'h100 + b * 32'h200 + i));
        else passed++;
      end
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      checks++; if (inflight_cnt !== 4'd0) $display("FAIL fw_drain got %0d exp 0", inflight_cnt); else passed++;
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp_pc [8];
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 16'(32'h400 + i), 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 16'h04FF, 16'h0, 1'b1, 1'b1, 1'b0);
    tick();
    checks++; if (inflight_cnt !== 4'd7) $display("FAIL sim_full_cnt got %0d exp 7", inflight_cnt); else passed++;
    checks++; if (upd_pc !== 16'h0400) $display("FAIL sim_full_pc got %0h exp 400", upd_pc); else passed++;
    drive(1'b1, 1'b1, 16'h04AA, 16'h0, 1'b1, 1'b1, 1'b0);
    tick();
    checks++; if (inflight_cnt !== 4'd7) $display("FAIL sim_pp_cnt got %0d exp 7", inflight_cnt); else passed++;
    checks++; if (upd_pc !== 16'h0401) $display("FAIL sim_pp_pc got %0h exp 401", upd_pc); else passed++;
    for (int i = 0; i < 6; i++) exp_pc[i] = 16'(32'h402 + i);
    exp_pc[6] = 16'h04AA;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
      tick();
      checks++;
      if (upd_pc !== exp_pc[i]) $display("FAIL sim_drain[%0d] got %0h exp %0h", i, upd_pc, exp_pc[i]);
      else passed++;
    end
    drive(1'b1, 1'b0, 16'h0500, 16'h0501, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 16'h0510, 16'h0511, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 16'h0520, 16'h0521, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (upd_valid !== 1'b0) $display("FAIL flush_upd_valid got %0h exp 0", upd_valid); else passed++;
    checks++; if (mispredict !== 1'b0) $display("FAIL flush_mispredict got %0h exp 0", mispredict); else passed++;
    checks++; if (inflight_cnt !== 4'd0) $display("FAIL flush_cnt got %0d exp 0", inflight_cnt); else passed++;
    checks++; if (pred_ready !== 1'b1 || res_ready !== 1'b0)
      $display("FAIL flush_ready got p=%0h r=%0h exp p=1 r=0", pred_ready, res_ready); else passed++;
    checks++; if (mispred_cnt !== 16'd1) $display("FAIL flush_mcnt got %0d exp 1", mispred_cnt); else passed++;
  endtask

  // Reference model: a plain queue of predictions plus a one-cycle bubble flag.
  task automatic test_random();
    ent_t        mq[$];
    ent_t        h;
    logic        bubble = 1'b0;
    logic        e_uv, e_ut, e_mp;
    logic [15:0] e_up = 16'h0, e_rp = 16'h0;
    int          e_mc = 0;
    logic        pv, rv, rt, fl, pr, rr;
    e_ut = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      pv = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 9) < 5);
      fl = ($urandom_range(0, 49) == 0);
      rt = 1'($urandom_range(0, 1));
      if (mq.size() > 0) rt = ($urandom_range(0, 9) == 0) ? !mq[0].tk : mq[0].tk;
      drive(pv, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), rv, rt, fl);
      pr = !bubble && mq.size() < 8;
      rr = !bubble && mq.size() > 0;
      checks++;
      if (pred_ready !== pr || res_ready !== rr)
        $display("FAIL rnd_ready[%0d] got p=%0h r=%0h exp p=%0h r=%0h", c, pred_ready, res_ready, pr, rr);
      else passed++;
      e_uv = 1'b0; e_mp = 1'b0;
      if (fl) begin
        mq.delete();
        bubble = 1'b0;
      end else if (bubble) begin
        bubble = 1'b0;
      end else begin
        if (rv && rr) begin
          h = mq.pop_front();
          e_uv = 1'b1; e_up = h.pc; e_ut = rt;
          if (rt != h.tk) begin
            e_mp = 1'b1; e_rp = h.alt;
            if (e_mc < 65535) e_mc++;
            mq.delete();
            bubble = 1'b1;
          end
        end
        if (pv && pr && !e_mp) mq.push_back('{tk: pred_taken, pc: pred_pc, alt: pred_alt_pc});
      end
      tick();
      checks++;
      if (upd_valid !== e_uv || upd_pc !== e_up || upd_taken !== e_ut)
        $display("FAIL rnd_upd[%0d] got v=%0h pc=%0h t=%0h exp v=%0h pc=%0h t=%0h", c, upd_valid,
                 upd_pc, upd_taken, e_uv, e_up, e_ut);
      else passed++;
      checks++;
      if (mispredict !== e_mp || recover_pc !== e_rp || mispred_cnt !== 16'(e_mc))
        $display("FAIL rnd_mp[%0d] got m=%0h rp=%0h cnt=%0d exp m=%0h rp=%0h cnt=%0d", c, mispredict,
                 recover_pc, mispred_cnt, e_mp, e_rp, e_mc);
      else passed++;
      checks++;
      if (inflight_cnt !== 4'(mq.size()))
        $display("FAIL rnd_cnt[%0d] got %0d exp %0d", c, inflight_cnt, mq.size());
      else passed++;
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    int exp_cnt;
    force dut.mispred_cnt = 16'hFFFD;
    tick();
    release dut.mispred_cnt;
    tick();
    checks++; if (mispred_cnt !== 16'hFFFD) $display("FAIL sat_preload got %0h exp fffd", mispred_cnt); else passed++;
    for (int k = 1; k <= 4; k++) begin
      exp_cnt = (32'hFFFD + k > 32'hFFFF) ? 32'hFFFF : 32'hFFFD + k;
      drive(1'b1, 1'b0, 16'h0600, 16'h0601, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (mispredict !== 1'b1 || mispred_cnt !== 16'(exp_cnt))
        $display("FAIL sat_cnt[%0d] got m=%0h cnt=%0h exp m=1 cnt=%0h", k, mispredict, mispred_cnt, exp_cnt);
      else passed++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_correct_path();
    test_mispredict();
    test_full_wrap();
    test_simultaneous();
    test_reset();
    test_random();
    test_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
